matrix_row_scanner: RTL and testbench
=====================================

// Module: matrix_row_scanner
// PURPOSE
// - Downstream display stage for the scrolling sign. Takes the 5x7 pixel frame the row
//   registers produce and drives the physical LED matrix one row at a time.
// - Frames are double-buffered, so a scroll step never tears a displayed frame.
// - Emits a frame-start strobe that upstream uses to pace its shifting.
// PARAMETERS
// - ROWS       5     matrix rows (L1..L5)
// - COLS       7     matrix columns (C1..C7)
// - SCAN_DIV   1000  CLK cycles per row slot; legal range SCAN_DIV >= BLANK_CYC+2
// - BLANK_CYC  8     blanking cycles at the start of each row slot (anti-ghosting)
// PORTS
// - CLK          in   1          system clock, all logic on rising edge
// - RST_N        in   1          asynchronous, active-low reset
// - enable       in   1          1 = scan running, 0 = display dark
// - frame_in     in   ROWS*COLS  pixel frame; bit r*COLS+c = column c+1, row r+1; 1 = lit
// - frame_valid  in   1          1-cycle strobe: capture frame_in
// - brightness   in   3          dimming level; used only with the macro, else ignored
// - row_sel      out  ROWS       one-hot row drive, active high
// - col_drv      out  COLS       column sink drive, active low (0 = LED on)
// - frame_start  out  1          1-cycle pulse on entering row 0 of a scan
// BEHAVIOUR
// - Reset (async, immediate):
//   - outputs: row_sel=0, col_drv=all 1, frame_start=0
//   - state: IDLE; shadow and display buffers=0; pending flag=0; counters=0
// - Capture: on frame_valid, frame_in goes to the shadow buffer and pending is set.
//   - Multiple strobes before a swap: last one wins.
//   - Capture is allowed in any state, including IDLE.
// - Swap: the display buffer loads from shadow only on entry to row 0 (wrap ROWS-1 -> 0,
//   or start from IDLE), and only if pending=1. Pending then clears.
//   - frame_valid in the same cycle as a swap: the new frame_in is swapped in directly
//     and pending stays 0.
// - FSM:
//   - IDLE -> BLANK (row 0) when enable=1.
//   - BLANK -> DRIVE after BLANK_CYC cycles.
//   - DRIVE -> BLANK (next row) after SCAN_DIV-BLANK_CYC cycles.
//   - Row index wraps ROWS-1 -> 0.
// - Outputs by state:
//   - BLANK: row_sel=0, col_drv=all 1.
//   - DRIVE: row_sel=1<<row, col_drv=~display[row*COLS +: COLS].
//   - All outputs are registered: they change the cycle after the state and counter
//     transition.
// - frame_start is high for exactly 1 cycle: the first BLANK cycle of row 0. Period is
//   ROWS*SCAN_DIV cycles.
// - Prescaler width is $clog2(SCAN_DIV). The slot counter resets to 0 at every row
//   boundary. No drift is allowed: every slot is exactly SCAN_DIV cycles.
// - enable=0 in any state: next cycle is IDLE, outputs blank, row=0, counters=0.
//   - Buffers and pending are kept.
//   - Re-enable restarts at row 0 BLANK with a frame_start pulse.
// - Reset mid-scan: immediate blank; the next enable starts from a zero display unless a
//   new frame is captured first.
// CONFIGURATION
// - BRIGHTNESS_PWM_EN defined:
//   - A 3-bit PWM counter resets at each DRIVE entry and increments every DRIVE cycle.
//   - Columns are driven only while pwm_cnt <= brightness; otherwise col_drv=all 1 and
//     row_sel stays asserted.
//   - Duty is (brightness+1)/8; brightness=7 gives full on.
//   - brightness is sampled at each DRIVE entry and held for the row.
// - BRIGHTNESS_PWM_EN undefined: brightness port exists but is ignored; full duty for the
//   whole DRIVE phase.
// TESTING (ROWS=5, COLS=7, SCAN_DIV=16, BLANK_CYC=2)
// - Reset: drop RST_N during DRIVE -> same cycle row_sel=0, col_drv=7'h7F,
//   frame_start=0.
// - Single pixel: frame_in=35'h1, frame_valid pulse, enable=1
//   -> row_sel=5'b00001 with col_drv=7'b1111110 in slot cycles 2..15 of row 0;
//   rows 1..4 keep col_drv=7'h7F.
// - Timing: full frame of 1s -> frame_start every 80 cycles; row_sel steps
//   1,2,4,8,16, each preceded by 2 blank cycles.
// - No tearing: frame A shown, frame B strobed during row 2 -> rows 2..4 still show A;
//   B appears from the next frame_start.
// - Enable drop: enable=0 during row 3 -> next cycle blank, IDLE;
//   enable=1 -> frame_start pulse, row 0 BLANK first.
// - PWM (macro on): brightness=3, all pixels lit -> in each DRIVE phase col_drv=0 for
//   4 of every 8 cycles.
//   Macro off: same stimulus gives col_drv=0 for all 14 DRIVE cycles.

Source files
------------

// File: rtl/matrix_row_scanner.sv
// matrix_row_scanner: row-multiplexed driver for a ROWS x COLS LED matrix.
// Frames are double-buffered (shadow -> display) and the swap happens only on
// entry to row 0, so a displayed frame never tears. Each row slot is SCAN_DIV
// cycles: BLANK_CYC cycles dark (anti-ghosting), then the row is driven.
// Optional feature macro: BRIGHTNESS_PWM_EN (3-bit PWM dimming in DRIVE).
module matrix_row_scanner #(
  parameter int ROWS      = 5,
  parameter int COLS      = 7,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] frame_in,
  input  logic                 frame_valid,
  input  logic [2:0]           brightness,
  output logic [ROWS-1:0]      row_sel,
  output logic [COLS-1:0]      col_drv,
  output logic                 frame_start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [ROW_W-1:0]     row;
  logic [ROWS*COLS-1:0] shadow;
  logic [ROWS*COLS-1:0] display;
  logic                 pending;

  logic             blank_done;
  logic             slot_done;
  logic             last_row;
  logic             swap;
  logic [COLS-1:0]  row_pix;
  logic             col_on;
  logic [ROWS-1:0]  row_onehot;

  assign blank_done = (state == BLANK) && (cnt == CNT_W'(BLANK_CYC - 1));
  assign slot_done  = (state == DRIVE) && (cnt == CNT_W'(SCAN_DIV - 1));
  assign last_row   = (row == ROW_W'(ROWS - 1));
  // Entering row 0: either a fresh start from IDLE or the wrap after the last row.
  assign swap       = enable && ((state == IDLE) || (slot_done && last_row));

  // Select the pixels of the current row from the display buffer.
  always_comb begin
    row_pix    = '0;
    row_onehot = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row == ROW_W'(r)) begin
        row_pix       = display[r*COLS +: COLS];
        row_onehot[r] = 1'b1;
      end
    end
  end

  // Scan FSM: row slot sequencing with a slot counter that restarts every row.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      row   <= '0;
    end else if (!enable) begin
      state <= IDLE;
      cnt   <= '0;
      row   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= BLANK;
          cnt   <= '0;
          row   <= '0;
        end
        BLANK: begin
          cnt <= cnt + CNT_W'(1);
          if (blank_done) state <= DRIVE;
        end
        DRIVE: begin
          if (slot_done) begin
            state <= BLANK;
            cnt   <= '0;
            row   <= last_row ? '0 : row + ROW_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          row   <= '0;
        end
      endcase
    end
  end

  // Frame capture into shadow and tear-free swap into display at row-0 entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
    end else begin
      if (frame_valid) shadow <= frame_in;
      if (swap) begin
        // A strobe coinciding with the swap bypasses the shadow entirely.
        if (frame_valid) begin
          display <= frame_in;
          pending <= 1'b0;
        end else if (pending) begin
          display <= shadow;
          pending <= 1'b0;
        end
      end else if (frame_valid) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef BRIGHTNESS_PWM_EN
  logic [2:0] pwm_cnt;
  logic [2:0] bright_q;

  // PWM phase restarts at each DRIVE entry; brightness is latched for the row.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pwm_cnt  <= '0;
      bright_q <= '0;
    end else if (enable && blank_done) begin
      pwm_cnt  <= '0;
      bright_q <= brightness;
    end else if (state == DRIVE) begin
      pwm_cnt <= pwm_cnt + 3'd1;
    end
  end

  assign col_on = (pwm_cnt <= bright_q);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign col_on            = 1'b1;
`endif

  // Registered outputs follow the current state; enable low blanks immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      row_sel     <= '0;
      col_drv     <= '1;
      frame_start <= 1'b0;
    end else begin
      row_sel     <= '0;
      col_drv     <= '1;
      frame_start <= 1'b0;
      if (enable) begin
        case (state)
          BLANK: frame_start <= (row == '0) && (cnt == '0);
          DRIVE: begin
            row_sel <= row_onehot;
            col_drv <= col_on ? ~row_pix : '1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Directed bench for matrix_row_scanner (ROWS=5, COLS=7, SCAN_DIV=16, BLANK_CYC=2).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_matrix_row_scanner;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        enable;
  logic [34:0] frame_in;
  logic        frame_valid;
  logic [2:0]  brightness;
  logic [4:0]  row_sel;
  logic [6:0]  col_drv;
  logic        frame_start;

  int checks = 0;
  int fails  = 0;
  int lat;

  localparam logic [34:0] FR_A   = 35'h1;
  localparam logic [34:0] FR_ONE = 35'h7_FFFF_FFFF;
  localparam logic [34:0] FR_X   = 35'h7;
  localparam logic [34:0] FR_Y   = 35'h3F80;

  always #5 CLK = ~CLK;

  matrix_row_scanner #(.ROWS(5), .COLS(7), .SCAN_DIV(16), .BLANK_CYC(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .frame_in(frame_in),
    .frame_valid(frame_valid), .brightness(brightness), .row_sel(row_sel),
    .col_drv(col_drv), .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_row"}, 32'(row_sel), 32'h0);
    chk({tag, "_col"}, 32'(col_drv), 32'h7F);
    chk({tag, "_fs"},  32'(frame_start), 32'h0);
  endtask

  // Bounded wait for frame_start; reports cycles taken.
  task automatic wait_fs(input int limit, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!frame_start && n < limit);
    chk("fs_seen", 32'(frame_start), 32'h1);
  endtask

  // Called at output cycle 0 of a frame; checks cycles 0..n-1 against the
  // expected display, optionally strobing sframe at cycle strobe_k.
  task automatic check_frame(input string tag, input logic [34:0] disp, input int n,
                             input int strobe_k, input logic [34:0] sframe);
    for (int k = 0; k < n; k++) begin
      int slot, r, d;
      logic drive, on;
      logic [4:0] e_rs;
      logic [6:0] e_col;
      slot  = k % 16;
      r     = k / 16;
      drive = (slot >= 2);
      d     = drive ? slot - 2 : 0;
`ifdef BRIGHTNESS_PWM_EN
      on = ((d % 8) <= int'(brightness));
`else
      on = (d >= 0);
`endif
      e_rs  = drive ? (5'b00001 << r) : 5'b0;
      e_col = (drive && on) ? ~disp[r*7 +: 7] : 7'h7F;
      chk($sformatf("%s_rs_k%0d", tag, k),  32'(row_sel), 32'(e_rs));
      chk($sformatf("%s_col_k%0d", tag, k), 32'(col_drv), 32'(e_col));
      chk($sformatf("%s_fs_k%0d", tag, k),  32'(frame_start), 32'(k == 0));
      frame_valid = (k == strobe_k);
      if (k == strobe_k) frame_in = sframe;
      @(negedge CLK);
    end
    frame_valid = 1'b0;
  endtask

  initial begin
    RST_N = 1'b1; enable = 1'b0; frame_in = '0; frame_valid = 1'b0; brightness = 3'd7;
    #2 RST_N = 1'b0;
    @(negedge CLK); @(negedge CLK);
    chk_blank("reset");
    RST_N = 1'b1;
    @(negedge CLK);
    chk_blank("idle");

    // Single pixel, captured while IDLE, swapped in at start.
    frame_in = FR_A; frame_valid = 1'b1;
    @(negedge CLK);
    frame_valid = 1'b0; enable = 1'b1;
    wait_fs(50, lat);
    chk("start_lat", 32'(lat), 32'd2);
    check_frame("pix", FR_A, 80, -1, '0);
    // No tearing: all-ones strobed in row 2; rows 2..4 keep showing A.
    check_frame("tear", FR_A, 80, 40, FR_ONE);
    // Shown from the next frame; enable dropped during row 3 (cycle 52).
    check_frame("full", FR_ONE, 52, -1, '0);
    enable = 1'b0;
    @(negedge CLK); chk_blank("drop0");
    frame_in = FR_X; frame_valid = 1'b1;
    @(negedge CLK); chk_blank("drop1");
    frame_in = FR_Y;
    @(negedge CLK); chk_blank("drop2");
    frame_valid = 1'b0;
    @(negedge CLK); chk_blank("drop3");
    // Re-enable: last strobe wins, row 0 BLANK with frame_start first.
    enable = 1'b1;
    wait_fs(50, lat);
    chk("reen_lat", 32'(lat), 32'd2);
    check_frame("last", FR_Y, 80, -1, '0);

    // Strobe coincident with the swap from IDLE goes straight to display.
    enable = 1'b0;
    @(negedge CLK); chk_blank("drop4");
    enable = 1'b1; frame_in = FR_ONE; frame_valid = 1'b1;
    @(negedge CLK);
    frame_valid = 1'b0;
    wait_fs(50, lat);
    chk("direct_lat", 32'(lat), 32'd1);
    check_frame("dir", FR_ONE, 80, -1, '0);
    check_frame("per", FR_ONE, 80, -1, '0);
    brightness = 3'd3;
    check_frame("pwm", FR_ONE, 80, -1, '0);
    brightness = 3'd7;

    // Reset during DRIVE of row 1 (cycle 20): immediate blank, zero display after.
    check_frame("pre_rst", FR_ONE, 20, -1, '0);
    chk("pre_rst_rs", 32'(row_sel), 32'h2);
    RST_N = 1'b0;
    #1;
    chk_blank("rst_mid");
    @(negedge CLK);
    RST_N = 1'b1;
    wait_fs(50, lat);
    chk("post_rst_lat", 32'(lat), 32'd2);
    check_frame("zero", '0, 80, -1, '0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
